// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader.
// Contents: rd_state_t, the reader FSM state encoding (also exported on the state port).
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Master write-data channel (valid/ready) carrying burst beats.
// Signals: maxi_data (beat payload), maxi_valid, maxi_ready, maxi_last (final beat of burst).
// Modports: master drives data/valid/last and samples ready; slave is the mirror.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] maxi_data;
  logic              maxi_valid;
  logic              maxi_ready;
  logic              maxi_last;

  modport master (output maxi_data, output maxi_valid, output maxi_last, input maxi_ready);
  modport slave  (input maxi_data, input maxi_valid, input maxi_last, output maxi_ready);
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry registered valid/ready buffer.
// Ports: clk, reset (sync, active-high), push/push_data (write side, caller gates on full),
//        out_valid/out_data/out_ready (registered read side), full (registered: both entries held).
// A pushed word reaches out_data on the next cycle when the output slot is free or draining.
module burst_skid_buf #(
  parameter int unsigned W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         full
);
  logic [W-1:0] sk_data;
  logic         pop;

  assign pop = out_valid && out_ready;

  // Output register plus one overflow slot; full mirrors the overflow slot's occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_data   <= '0;
      full      <= 1'b0;
    end else if (!out_valid || pop) begin
      if (full) begin
        out_data  <= sk_data;
        out_valid <= 1'b1;
        if (push) sk_data <= push_data;
        else      full    <= 1'b0;
      end else if (push) begin
        out_data  <= push_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      sk_data <= push_data;
      full    <= 1'b1;
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops BURST_LEN-word bursts from an FWFT FIFO into a skid stage feeding
// a valid/ready master channel, with last marking, underrun flag and burst statistics.
// Ports: read_clk, reset (sync, active-high); fifo_data/fifo_empty/rd_en (FWFT FIFO, rd_en
//        combinational); burst_ready (level, a full burst is buffered); maxi (master channel);
//        state, read_cnt, wait_cnt, burst_cnt, underrun (status).
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LANE_W     = 16,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned WAIT_W     = 16
) (
  input  logic                           read_clk,
  input  logic                           reset,
  input  logic [LANES*LANE_W-1:0]        fifo_data,
  input  logic                           fifo_empty,
  output logic                           rd_en,
  input  logic                           burst_ready,
  fifo_burst_reader_if.master            maxi,
  output logic [1:0]                     state,
  output logic [$clog2(BURST_LEN+1)-1:0] read_cnt,
  output logic [WAIT_W-1:0]              wait_cnt,
  output logic [15:0]                    burst_cnt,
  output logic                           underrun
);
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  rd_state_t          state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_tag;
  logic               skid_valid, skid_full;
  logic [DATA_W:0]    skid_data;
  logic               beat_acc, last_acc, start;

  assign last_tag = (issue_cnt == CNT_W'(BURST_LEN - 1));
  assign beat_acc = skid_valid && maxi.maxi_ready;
  assign last_acc = beat_acc && skid_data[DATA_W];
  assign start    = (state_q == S_IDLE) && burst_ready;
  assign state    = state_q;

  // State register
  always_ff @(posedge read_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (burst_ready) state_d = S_BURST;
      S_BURST: if (rd_en && last_tag) state_d = S_DRAIN;
      S_DRAIN: if (last_acc) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pop strobe: only while bursting, with data present, words outstanding and skid room
  always_comb begin
    rd_en = 1'b0;
    if (state_q == S_BURST)
      rd_en = !fifo_empty && (issue_cnt < CNT_W'(BURST_LEN)) && !skid_full;
  end

  // Burst counters, idle wait counter and sticky underrun
  always_ff @(posedge read_clk) begin
    if (reset) begin
      issue_cnt <= '0;
      read_cnt  <= '0;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      underrun  <= 1'b0;
    end else begin
      if (start) begin
        issue_cnt <= '0;
        read_cnt  <= '0;
        wait_cnt  <= '0;
      end else begin
        if ((state_q == S_IDLE) && (wait_cnt != {WAIT_W{1'b1}}))
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (rd_en)    issue_cnt <= issue_cnt + CNT_W'(1);
        if (beat_acc) read_cnt  <= read_cnt + CNT_W'(1);
      end
      if (last_acc) burst_cnt <= burst_cnt + 16'd1;
      if (state_q == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                  gap_cnt <= '0;
      if ((state_q == S_BURST) && fifo_empty && (issue_cnt < CNT_W'(BURST_LEN)))
        underrun <= 1'b1;
    end
  end

  // Last tag rides alongside its data word through the skid
  burst_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (read_clk),
    .reset     (reset),
    .push      (rd_en),
    .push_data ({last_tag, fifo_data}),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (maxi.maxi_ready),
    .full      (skid_full)
  );

  assign maxi.maxi_valid = skid_valid;
  assign maxi.maxi_data  = skid_data[DATA_W-1:0];
  assign maxi.maxi_last  = skid_data[DATA_W];
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader (LANES=4, LANE_W=16, BURST_LEN=8, GAP_CYCLES=2, WAIT_W=4).
module tb_fifo_burst_reader;
  logic        read_clk = 1'b0;
  logic        reset;
  logic [63:0] fifo_data;
  logic        fifo_empty;
  logic        rd_en;
  logic        burst_ready;
  logic [1:0]  state;
  logic [3:0]  read_cnt;
  logic [3:0]  wait_cnt;
  logic [15:0] burst_cnt;
  logic        underrun;

  fifo_burst_reader_if #(.DATA_W(64)) bus ();

  fifo_burst_reader #(
    .LANES(4), .LANE_W(16), .BURST_LEN(8), .GAP_CYCLES(2), .WAIT_W(4)
  ) dut (
    .read_clk   (read_clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .burst_ready(burst_ready),
    .maxi       (bus.master),
    .state      (state),
    .read_cnt   (read_cnt),
    .wait_cnt   (wait_cnt),
    .burst_cnt  (burst_cnt),
    .underrun   (underrun)
  );

  always #5 read_clk = ~read_clk;

  typedef struct {
    logic       br;
    logic       rdy;
    logic [1:0] st;
    logic       rd;
    logic       v;
    int         beat;
    logic       last;
    logic [3:0] wt;
  } vec_t;

  vec_t        vecs [13];
  logic [63:0] fq [$];
  logic [64:0] recv [$];
  logic [64:0] prev_beat;
  logic        prev_stall;
  int          passed, total;
  int          hold_seen, stall_seen, stall_err;

  function automatic logic [63:0] word(input int k);
    logic [15:0] s;
    s = 16'(k);
    return {16'h4000 + s, 16'h3000 + s, 16'h2000 + s, 16'h1000 + s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 64'd0 : fq[0];
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(word(base + i));
    drive_fifo();
  endtask

  // One clock: sample away from the edge, then model the FWFT pop and refresh the head word
  task automatic step();
    logic pop;
    #1;
    pop = rd_en;
    if (state == 2'd1 && !fifo_empty && !rd_en) hold_seen++;
    if (prev_stall) begin
      stall_seen++;
      if (!bus.maxi_valid || {bus.maxi_last, bus.maxi_data} != prev_beat) stall_err++;
    end
    prev_stall = bus.maxi_valid && !bus.maxi_ready;
    prev_beat  = {bus.maxi_last, bus.maxi_data};
    if (bus.maxi_valid && bus.maxi_ready) recv.push_back({bus.maxi_last, bus.maxi_data});
    @(posedge read_clk);
    #1;
    if (reset) prev_stall = 1'b0;
    if (pop && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
    #1;
  endtask

  task automatic start_burst();
    burst_ready = 1'b1;
    step();
    burst_ready = 1'b0;
  endtask

  task automatic run_beats(input string nm, input int n, input int budget, input bit toggle);
    int k = 0;
    while (recv.size() < n && k < budget) begin
      if (toggle) bus.maxi_ready = !bus.maxi_ready;
      step();
      k++;
    end
    chk({nm, "_beats_in_time"}, 64'(recv.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (state != 2'd0 && k < 40) begin
      step();
      k++;
    end
    chk({nm, "_idle"}, 64'(state), 64'd0);
  endtask

  task automatic check_beats(input string nm, input int base);
    chk({nm, "_count"}, 64'(recv.size()), 64'd8);
    for (int i = 0; i < recv.size() && i < 8; i++) begin
      chk($sformatf("%s_data%0d", nm, i), recv[i][63:0], word(base + i));
      chk($sformatf("%s_last%0d", nm, i), 64'(recv[i][64]), 64'(i == 7));
    end
  endtask

  initial begin
    passed = 0; total = 0;
    hold_seen = 0; stall_seen = 0; stall_err = 0;
    prev_stall = 1'b0; prev_beat = '0;

    // Nominal burst, cycle by cycle: {br, rdy, state, rd_en, valid, beat, last, wait_cnt}
    vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 4'd15};
    vecs[1] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 0, 1'b0, 4'd0};
    for (int i = 2; i <= 8; i++) vecs[i] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, i - 1, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8, 1'b1, 4'd0};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 0, 1'b0, 4'd0};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 0, 1'b0, 4'd0};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 4'd0};

    reset = 1'b1; burst_ready = 1'b0; bus.maxi_ready = 1'b0;
    drive_fifo();
    step(); step();
    reset = 1'b0;

    chk("rst_valid",     64'(bus.maxi_valid), 64'd0);
    chk("rst_data",      bus.maxi_data,       64'd0);
    chk("rst_last",      64'(bus.maxi_last),  64'd0);
    chk("rst_state",     64'(state),          64'd0);
    chk("rst_read_cnt",  64'(read_cnt),       64'd0);
    chk("rst_wait_cnt",  64'(wait_cnt),       64'd0);
    chk("rst_burst_cnt", 64'(burst_cnt),      64'd0);
    chk("rst_underrun",  64'(underrun),       64'd0);
    chk("rst_rd_en",     64'(rd_en),          64'd0);

    // Idle wait counter counts then saturates
    for (int i = 0; i < 5; i++) step();
    chk("wait_cnt_5", 64'(wait_cnt), 64'd5);
    for (int i = 0; i < 15; i++) step();
    chk("wait_cnt_sat", 64'(wait_cnt), 64'd15);

    // Nominal burst from the vector table
    preload(1, 8);
    for (int i = 0; i < 13; i++) begin
      burst_ready = vecs[i].br;
      bus.maxi_ready = vecs[i].rdy;
      #1;
      chk($sformatf("nom_state%0d", i), 64'(state),          64'(vecs[i].st));
      chk($sformatf("nom_rd_en%0d", i), 64'(rd_en),          64'(vecs[i].rd));
      chk($sformatf("nom_valid%0d", i), 64'(bus.maxi_valid), 64'(vecs[i].v));
      chk($sformatf("nom_wait%0d", i),  64'(wait_cnt),       64'(vecs[i].wt));
      if (vecs[i].v) begin
        chk($sformatf("nom_data%0d", i), bus.maxi_data,       word(vecs[i].beat));
        chk($sformatf("nom_last%0d", i), 64'(bus.maxi_last),  64'(vecs[i].last));
      end
      step();
    end
    burst_ready = 1'b0;
    chk("nom_read_cnt",  64'(read_cnt),  64'd8);
    chk("nom_burst_cnt", 64'(burst_cnt), 64'd1);
    chk("nom_underrun",  64'(underrun),  64'd0);
    check_beats("nom", 1);

    // Backpressure: ready toggles every cycle
    recv.delete(); hold_seen = 0; stall_seen = 0; stall_err = 0;
    preload(11, 8);
    bus.maxi_ready = 1'b1;
    start_burst();
    run_beats("bp", 8, 60, 1'b1);
    check_beats("bp", 11);
    chk("bp_stalls_seen",  64'(stall_seen > 0), 64'd1);
    chk("bp_stall_stable", 64'(stall_err),      64'd0);
    chk("bp_rd_en_held",   64'(hold_seen > 0),  64'd1);
    bus.maxi_ready = 1'b1;
    wait_idle("bp");
    chk("bp_burst_cnt", 64'(burst_cnt), 64'd2);
    chk("bp_read_cnt",  64'(read_cnt),  64'd8);

    // Underrun: 5 words, remaining 3 arrive 10 cycles after the start pulse
    recv.delete();
    preload(21, 5);
    start_burst();
    for (int i = 1; i < 10; i++) step();
    chk("ur_flag_set",    64'(underrun),    64'd1);
    chk("ur_stall_beats", 64'(recv.size()), 64'd5);
    chk("ur_stall_state", 64'(state),       64'd1);
    preload(26, 3);
    run_beats("ur", 8, 40, 1'b0);
    check_beats("ur", 21);
    wait_idle("ur");
    chk("ur_flag_sticky", 64'(underrun),  64'd1);
    chk("ur_burst_cnt",   64'(burst_cnt), 64'd3);

    // Reset in the middle of a burst
    recv.delete();
    preload(31, 8);
    start_burst();
    run_beats("mr", 3, 20, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid",     64'(bus.maxi_valid), 64'd0);
    chk("mr_last",      64'(bus.maxi_last),  64'd0);
    chk("mr_data",      bus.maxi_data,       64'd0);
    chk("mr_state",     64'(state),          64'd0);
    chk("mr_read_cnt",  64'(read_cnt),       64'd0);
    chk("mr_burst_cnt", 64'(burst_cnt),      64'd0);
    chk("mr_underrun",  64'(underrun),       64'd0);
    fq.delete(); recv.delete();
    drive_fifo();

    // Next burst after reset, also checking lane order
    fq.push_back(64'h4444_3333_2222_1111);
    preload(42, 7);
    start_burst();
    chk("ln_state",      64'(state),    64'd1);
    chk("ln_wait_clear", 64'(wait_cnt), 64'd0);
    chk("ln_read_cnt0",  64'(read_cnt), 64'd0);
    run_beats("ln", 8, 40, 1'b0);
    chk("ln_count",  64'(recv.size()),      64'd8);
    chk("ln_lane0",  64'(recv[0][15:0]),    64'h1111);
    chk("ln_lane1",  64'(recv[0][31:16]),   64'h2222);
    chk("ln_lane3",  64'(recv[0][63:48]),   64'h4444);
    chk("ln_first_not_last", 64'(recv[0][64]), 64'd0);
    chk("ln_beat2",  recv[1][63:0],         word(42));
    chk("ln_last",   64'(recv[7][64]),      64'd1);
    wait_idle("ln");
    chk("ln_read_cnt",  64'(read_cnt),  64'd8);
    chk("ln_burst_cnt", 64'(burst_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
